// File: rtl/uart_tx_arb.sv
// Round-robin, packet-locking arbiter sharing one uart_tx among NREQ byte-stream requesters.
// A winner keeps the transmitter until its last byte completes or its inter-byte hold timer expires.
module uart_tx_arb #(
    parameter int NREQ         = 4,
    parameter int HOLD_TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    input  logic              tx_end,
    output logic [NREQ-1:0]   msg_done,
    output logic [NREQ-1:0]   hold_err
);

    localparam int          PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] msg_done_q, msg_done_d;
    logic [NREQ-1:0] hold_err_q, hold_err_d;
    logic [7:0]      data_q, data_d;
    logic            last_q, last_d;
    logic [15:0]     hold_cnt_q, hold_cnt_d;

    logic [7:0]      req_byte [NREQ];
    logic            found;
    logic [PW-1:0]   win_idx;
    logic [NREQ-1:0] win_onehot;
    logic [PW-1:0]   sel_idx;
    logic [7:0]      sel_data;
    logic            sel_last;
    logic            owner_valid;
    logic [PW-1:0]   next_ptr;
    logic [NREQ-1:0] ready_vec;
    logic            start_c;
    int              cand;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_byte[gi] = req_data[gi*8 +: 8];
        end
    endgenerate

    // Rotating priority search: first valid requester at or after the pointer wins.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = (int'(ptr_q) + i) % NREQ;
            if (!found && ((req_valid & (NREQ'(1) << cand)) != '0)) begin
                found   = 1'b1;
                win_idx = PW'(cand);
            end
        end
    end

    assign win_onehot  = NREQ'(1) << win_idx;
    assign sel_idx     = (state_q == IDLE) ? win_idx : owner_q;
    assign owner_valid = (req_valid & grant_q) != '0;
    assign next_ptr    = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        sel_data = 8'h00;
        sel_last = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == sel_idx) begin
                sel_data = req_byte[i];
                sel_last = req_last[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        data_d     = data_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        msg_done_d = '0;
        hold_err_d = '0;
        ready_vec  = '0;
        start_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    ready_vec = win_onehot;
                    data_d    = sel_data;
                    last_d    = sel_last;
                    grant_d   = win_onehot;
                    owner_d   = win_idx;
                    state_d   = START;
                end else begin
                    grant_d = '0;
                end
            end
            START: begin
                if (!tx_busy) begin
                    start_c = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (tx_end) begin
                    if (last_q) begin
                        msg_done_d = grant_q;
                        grant_d    = '0;
                        ptr_d      = next_ptr;
                        state_d    = IDLE;
                    end else begin
                        hold_cnt_d = 16'h0000;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (owner_valid) begin
                    ready_vec = grant_q;
                    data_d    = sel_data;
                    last_d    = sel_last;
                    state_d   = START;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    hold_err_d = grant_q;
                    grant_d    = '0;
                    ptr_d      = next_ptr;
                    state_d    = IDLE;
                end else if (hold_cnt_q != 16'hFFFF) begin
                    hold_cnt_d = hold_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            grant_q    <= '0;
            msg_done_q <= '0;
            hold_err_q <= '0;
            data_q     <= 8'h00;
            last_q     <= 1'b0;
            hold_cnt_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            msg_done_q <= msg_done_d;
            hold_err_q <= hold_err_d;
            data_q     <= data_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Ready and start are combinational; masking keeps them quiet while reset is held.
    assign req_ready = ready_vec & {NREQ{reset}};
    assign tx_start  = start_c & reset;
    assign grant     = grant_q;
    assign tx_data   = data_q;
    assign msg_done  = msg_done_q;
    assign hold_err  = hold_err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: per-requester byte sources, a small uart_tx model,
// and an accept/start log compared against hand-built expectations.
module tb_uart_tx_arb;

    localparam int NREQ  = 4;
    localparam int FRAME = 6;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic              tx_end;
    logic [NREQ-1:0]   msg_done;
    logic [NREQ-1:0]   hold_err;

    uart_tx_arb #(.NREQ(NREQ), .HOLD_TIMEOUT(8)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .tx_end    (tx_end),
        .msg_done  (msg_done),
        .hold_err  (hold_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // uart_tx model: busy for FRAME cycles after a start, then a one-cycle tx_end.
    logic model_busy;
    int   model_cnt;
    logic force_busy;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_busy <= 1'b0;
            model_cnt  <= 0;
            tx_end     <= 1'b0;
        end else begin
            tx_end <= 1'b0;
            if (tx_start) begin
                model_busy <= 1'b1;
                model_cnt  <= FRAME;
            end else if (model_busy) begin
                if (model_cnt == 1) begin
                    model_busy <= 1'b0;
                    tx_end     <= 1'b1;
                end else begin
                    model_cnt <= model_cnt - 1;
                end
            end
        end
    end
    assign tx_busy = model_busy | force_busy;

    // Byte sources: each requester presents the head of its list until it sees ready.
    logic [8:0]      src_mem [NREQ][16];
    int              head [NREQ];
    int              tail [NREQ];
    logic [NREQ-1:0] rdy_seen;

    task automatic push(input int r, input logic [7:0] d, input logic l);
        src_mem[r][tail[r]] = {l, d};
        tail[r]++;
    endtask

    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (rdy_seen[i] && head[i] < tail[i]) head[i]++;
                if (head[i] < tail[i]) begin
                    req_valid[i]       = 1'b1;
                    req_data[i*8 +: 8] = src_mem[i][head[i]][7:0];
                    req_last[i]        = src_mem[i][head[i]][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[i*8 +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
        end
    end

    // Transaction monitor
    logic [3:0] acc_vec [32];
    logic [7:0] acc_dat [32];
    logic [7:0] start_dat [32];
    int         acc_n      = 0;
    int         start_n    = 0;
    int         busy_viol  = 0;
    initial begin
        forever begin
            @(negedge clk);
            rdy_seen = req_ready;
            if (rst_n) begin
                if (req_ready != '0) begin
                    acc_vec[acc_n] = req_ready;
                    acc_dat[acc_n] = 8'h00;
                    for (int i = 0; i < NREQ; i++)
                        if (req_ready[i]) acc_dat[acc_n] = req_data[i*8 +: 8];
                    $display("t=%0t accept ready=%b data=%h", $time, req_ready, acc_dat[acc_n]);
                    acc_n++;
                end
                if (tx_start) begin
                    start_dat[start_n] = tx_data;
                    $display("t=%0t tx_start data=%h busy=%b", $time, tx_data, tx_busy);
                    if (tx_busy) busy_viol++;
                    start_n++;
                end
            end
        end
    end

    logic [3:0] exp_vec [32];
    logic [7:0] exp_dat [32];
    int         exp_n   = 0;
    int         log_chk = 0;

    task automatic expect_acc(input logic [3:0] v, input logic [7:0] d);
        exp_vec[exp_n] = v;
        exp_dat[exp_n] = d;
        exp_n++;
    endtask

    task automatic check_log(input string tag);
        check_eq({tag, "_acc_n"}, acc_n, exp_n);
        check_eq({tag, "_start_n"}, start_n, exp_n);
        for (int i = log_chk; i < exp_n && i < acc_n; i++) begin
            check_eq($sformatf("%s_acc_vec%0d", tag, i), acc_vec[i], exp_vec[i]);
            check_eq($sformatf("%s_acc_dat%0d", tag, i), acc_dat[i], exp_dat[i]);
            if (i < start_n)
                check_eq($sformatf("%s_start_dat%0d", tag, i), start_dat[i], exp_dat[i]);
        end
        log_chk = exp_n;
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (req_ready == '0 && k < 50) begin @(negedge clk); k++; end
        check_eq({tag, "_ready_timeout"}, k < 50, 1);
    endtask

    task automatic wait_end(input string tag);
        int k = 0;
        while (tx_end == 1'b0 && k < 50) begin @(negedge clk); k++; end
        check_eq({tag, "_end_timeout"}, k < 50, 1);
    endtask

    task automatic wait_drain(input string tag, input int target);
        int k = 0;
        while (acc_n < target && k < 1000) begin @(negedge clk); k++; end
        @(negedge clk);
        while (msg_done == '0 && k < 1000) begin @(negedge clk); k++; end
        check_eq({tag, "_drain_timeout"}, k < 1000, 1);
        @(negedge clk);
    endtask

    task automatic flush_sources();
        for (int i = 0; i < NREQ; i++) head[i] = tail[i];
        rdy_seen = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush_sources();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got expired expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int k;
        rst_n      = 1'b0;
        force_busy = 1'b0;
        rdy_seen   = '0;
        for (int i = 0; i < NREQ; i++) begin head[i] = 0; tail[i] = 0; end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check_eq("rst_grant", grant, 0);
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_start", tx_start, 0);
        check_eq("rst_data", tx_data, 0);
        check_eq("rst_done", msg_done, 0);
        check_eq("rst_err", hold_err, 0);

        // Single requester, single-byte message
        push(1, 8'h41, 1'b1);
        expect_acc(4'b0010, 8'h41);
        wait_ready("t1");
        check_eq("t1_ready", req_ready, 4'b0010);
        check_eq("t1_grant_acc", grant, 0);
        @(negedge clk);
        check_eq("t1_start", tx_start, 1);
        check_eq("t1_data", tx_data, 8'h41);
        check_eq("t1_grant", grant, 4'b0010);
        wait_end("t1");
        check_eq("t1_grant_end", grant, 4'b0010);
        check_eq("t1_done_early", msg_done, 0);
        @(negedge clk);
        check_eq("t1_done", msg_done, 4'b0010);
        check_eq("t1_grant_clr", grant, 0);
        @(negedge clk);
        check_eq("t1_done_pulse", msg_done, 0);
        check_log("t1");

        // Round robin from pointer 0
        do_reset();
        push(0, 8'hA0, 1'b1);
        push(2, 8'hA2, 1'b1);
        push(3, 8'hA3, 1'b1);
        push(0, 8'hB0, 1'b1);
        expect_acc(4'b0001, 8'hA0);
        expect_acc(4'b0100, 8'hA2);
        expect_acc(4'b1000, 8'hA3);
        expect_acc(4'b0001, 8'hB0);
        wait_drain("t2", exp_n);
        check_log("t2");

        // Packet lock: pointer is 1, requester 1 holds the lock for three bytes
        push(1, 8'h10, 1'b0);
        push(1, 8'h11, 1'b0);
        push(1, 8'h12, 1'b1);
        push(0, 8'hC0, 1'b1);
        expect_acc(4'b0010, 8'h10);
        expect_acc(4'b0010, 8'h11);
        expect_acc(4'b0010, 8'h12);
        expect_acc(4'b0001, 8'hC0);
        wait_drain("t3", exp_n);
        check_log("t3");

        // Hold timeout: requester 2 sends a non-last byte then goes quiet
        push(2, 8'h22, 1'b0);
        push(3, 8'h33, 1'b1);
        expect_acc(4'b0100, 8'h22);
        expect_acc(4'b1000, 8'h33);
        wait_end("t4");
        k = 0;
        while (hold_err == '0 && k < 30) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check_eq("t4_grant_hold", grant, 4'b0100);
                check_eq("t4_ignore_other", req_ready, 0);
            end
        end
        check_eq("t4_err_latency", k, 9);
        check_eq("t4_err", hold_err, 4'b0100);
        check_eq("t4_grant_clr", grant, 0);
        check_eq("t4_next_ready", req_ready, 4'b1000);
        @(negedge clk);
        check_eq("t4_err_pulse", hold_err, 0);
        wait_drain("t4", exp_n);
        check_log("t4");

        // Busy backpressure
        force_busy = 1'b1;
        push(0, 8'h55, 1'b1);
        expect_acc(4'b0001, 8'h55);
        wait_ready("t5");
        check_eq("t5_ready", req_ready, 4'b0001);
        k = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx_start !== 1'b0 || tx_data !== 8'h55) k++;
        end
        check_eq("t5_stall_cycles_bad", k, 0);
        @(posedge clk);
        #1 force_busy = 1'b0;
        @(negedge clk);
        check_eq("t5_start", tx_start, 1);
        check_eq("t5_data", tx_data, 8'h55);
        @(negedge clk);
        check_eq("t5_start_once", tx_start, 0);
        wait_drain("t5", exp_n);
        check_log("t5");

        // Reset while the owner waits for tx_end
        push(2, 8'h66, 1'b1);
        expect_acc(4'b0100, 8'h66);
        k = 0;
        while (tx_start == 1'b0 && k < 50) begin @(negedge clk); k++; end
        check_eq("t6_start_timeout", k < 50, 1);
        @(negedge clk);
        check_eq("t6_grant_wait", grant, 4'b0100);
        #2 rst_n = 1'b0;
        flush_sources();
        #1;
        check_eq("t6_rst_grant", grant, 0);
        check_eq("t6_rst_start", tx_start, 0);
        check_eq("t6_rst_ready", req_ready, 0);
        check_eq("t6_rst_data", tx_data, 0);
        check_eq("t6_rst_done", msg_done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(0, 8'h70, 1'b1);
        push(1, 8'h71, 1'b1);
        expect_acc(4'b0001, 8'h70);
        expect_acc(4'b0010, 8'h71);
        wait_drain("t6", exp_n);
        check_log("t6");

        check_eq("start_while_busy", busy_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
